// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory / MMIO block.
//   - region select bit positions and IO word-index map
//   - load/store size encodings (funct3)
//   - response pipeline stage record
//   - helpers: funct3 legality, alignment, byte enables, store lane
//     replication, ID ROM contents
package dmem_pkg;

    localparam int RAM_SEL_BIT = 31;   // addr[31]=1 -> RAM
    localparam int IO_SEL_BIT  = 20;   // addr[31]=0, addr[20]=1 -> IO
    localparam int IO_IDX_MSB  = 11;
    localparam int IO_IDX_LSB  = 2;

    localparam logic [9:0] IO_IDX_COUNTER  = 10'd8;
    localparam logic [9:0] IO_IDX_SW_BASE  = 10'd16;  // switch ch n at 16+2n
    localparam logic [9:0] IO_IDX_LED_BASE = 10'd17;  // LED ch n at 17+2n

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // One in-flight request as it travels to the response port.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic        load;     // non-error load: rdata carries data
        logic        ram;      // data comes from RAM, else from io_data
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [31:0] io_data;
    } pipe_t;

    // Unsigned sizes only make sense for loads; a store using them is rejected.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return ~we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return |lo;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << lo;
            F3_H, F3_HU: return lo[1] ? 4'b1100 : 4'b0011;
            F3_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

    // Replicate the low byte/half across the word so every lane sees it.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_B, F3_BU: return {4{wdata[7:0]}};
            F3_H, F3_HU: return {2{wdata[15:0]}};
            default:     return wdata;
        endcase
    endfunction

    function automatic logic [31:0] rom_word(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h444D_454D;   // "DMEM"
            3'd1:    return 32'h0001_0200;   // version 1.2.0
            3'd2:    return 32'hC0DE_F00D;
            3'd3:    return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: request/response bus of the data-memory / MMIO block.
//   req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata
//   resp_valid, resp_rdata (extended load data), resp_err
//   master: the CPU side; slave: dmem_mmio.
interface dmem_mmio_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_mmio_load_ext.sv
// load_ext: combinational load formatter.
//   word   : full 32-bit word read from RAM/IO
//   lane   : addr[1:0] of the load
//   funct3 : access size / signedness
//   data   : addressed byte/half, sign- or zero-extended (word passes through)
module load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: byte-addressable data RAM plus a small MMIO block.
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : request/response bus (slave side), one request per cycle,
//                in-order responses READ_LAT cycles after acceptance
//   switch     : 16*GPIO_CH switch inputs (2-flop synchronised)
//   led        : 16*GPIO_CH LED outputs
// RAM lives at addr[31]=1; IO at addr[31]=0 & addr[20]=1 with ID ROM, free
// running cycle counter, switch and LED channels.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int ROM_WORDS = 3,
    parameter int GPIO_CH   = 2,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    dmem_mmio_if.slave           bus,
    input  logic [16*GPIO_CH-1:0] switch,
    output logic [16*GPIO_CH-1:0] led
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int GW     = 16 * GPIO_CH;
    localparam logic [9:0] ROM_LIMIT = 10'(ROM_WORDS);

    logic          ready_reg;
    logic [31:0]   counter_reg;
    logic [GW-1:0] sw_meta_reg, sw_sync_reg, led_reg;

    logic              accept, sel_ram, sel_io, req_err, ram_we, io_we;
    logic [RAM_AW-1:0] ram_idx;
    logic [9:0]        io_idx;
    logic [3:0]        be;
    logic [31:0]       wlane, io_rdata, ram_rd_word;
    logic              unused_addr;

    assign accept  = bus.req_valid & ready_reg;
    assign sel_ram = bus.req_addr[RAM_SEL_BIT];
    assign sel_io  = ~bus.req_addr[RAM_SEL_BIT] & bus.req_addr[IO_SEL_BIT];
    assign req_err = ~(sel_ram | sel_io)
                   | ~funct3_legal(bus.req_funct3, bus.req_we)
                   | is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign ram_idx = bus.req_addr[RAM_AW+1:2];
    assign io_idx  = bus.req_addr[IO_IDX_MSB:IO_IDX_LSB];
    assign be      = byte_enables(bus.req_funct3, bus.req_addr[1:0]);
    assign wlane   = store_lanes(bus.req_funct3, bus.req_wdata);
    assign ram_we  = accept & bus.req_we & sel_ram & ~req_err;
    assign io_we   = accept & bus.req_we & sel_io & ~req_err;
    // Most address bits are don't-care for decode.
    assign unused_addr = ^bus.req_addr;

    // Ready comes up on the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_reg   <= 1'b0;
            counter_reg <= '0;
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            ready_reg   <= 1'b1;
            counter_reg <= counter_reg + 32'd1;
            sw_meta_reg <= switch;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // LED channels hold 16 bits; lanes 2/3 of a store are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_reg <= '0;
        end else if (io_we) begin
            for (int n = 0; n < GPIO_CH; n++) begin
                if (io_idx == IO_IDX_LED_BASE + 10'(2 * n)) begin
                    if (be[0]) led_reg[16*n +: 8]   <= wlane[7:0];
                    if (be[1]) led_reg[16*n+8 +: 8] <= wlane[15:8];
                end
            end
        end
    end
    assign led = led_reg;

    // IO read value, captured at acceptance. Unlisted indices read 0.
    always_comb begin
        io_rdata = '0;
        if (io_idx < ROM_LIMIT)
            io_rdata = rom_word(io_idx[2:0]);
        else if (io_idx == IO_IDX_COUNTER)
            io_rdata = counter_reg;
        for (int n = 0; n < GPIO_CH; n++) begin
            if (io_idx == IO_IDX_SW_BASE + 10'(2 * n))
                io_rdata = {16'h0, sw_sync_reg[16*n +: 16]};
            if (io_idx == IO_IDX_LED_BASE + 10'(2 * n))
                io_rdata = {16'h0, led_reg[16*n +: 16]};
        end
    end

    // One block RAM per byte lane; read-first so a read sees pre-write data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [RAM_WORDS];
        logic [7:0] rd_reg;
        always_ff @(posedge clk) begin
            if (ram_we && be[gi])
                mem[ram_idx] <= wlane[8*gi +: 8];
            if (accept)
                rd_reg <= mem[ram_idx];
        end
        assign ram_rd_word[8*gi +: 8] = rd_reg;
    end

    pipe_t s1_next, s1_reg, out_stage;
    logic [31:0] out_ram_word, sel_word, ext_data;

    always_comb begin
        s1_next         = '0;
        s1_next.valid   = accept;
        s1_next.err     = req_err;
        s1_next.load    = ~bus.req_we & ~req_err;
        s1_next.ram     = sel_ram;
        s1_next.funct3  = bus.req_funct3;
        s1_next.lane    = bus.req_addr[1:0];
        s1_next.io_data = io_rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s1_reg <= '0;
        else       s1_reg <= s1_next;
    end

    if (READ_LAT == 2) begin : g_lat2
        pipe_t       s2_reg;
        logic [31:0] ram_word_reg;   // not reset: qualified by s2_reg.valid
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) s2_reg <= '0;
            else       s2_reg <= s1_reg;
        end
        always_ff @(posedge clk) ram_word_reg <= ram_rd_word;
        assign out_stage    = s2_reg;
        assign out_ram_word = ram_word_reg;
    end else begin : g_lat1
        assign out_stage    = s1_reg;
        assign out_ram_word = ram_rd_word;
    end

    assign sel_word = out_stage.ram ? out_ram_word : out_stage.io_data;

    load_ext u_load_ext (
        .word   (sel_word),
        .lane   (out_stage.lane),
        .funct3 (out_stage.funct3),
        .data   (ext_data)
    );

    assign bus.req_ready  = ready_reg;
    assign bus.resp_valid = out_stage.valid;
    assign bus.resp_err   = out_stage.valid & out_stage.err;
    // Gating by valid also makes rdata read 0 while reset is asserted.
    assign bus.resp_rdata = (out_stage.valid & out_stage.load) ? ext_data : '0;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench for dmem_mmio. dut_a uses READ_LAT=1,
// dut_b uses READ_LAT=2 with a 64-word RAM.
module tb_dmem_mmio;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] BAD_F3 = 3'b011;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] sw;
    logic [31:0] led_a, led_b;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_mmio_if bus_a ();
    dmem_mmio_if bus_b ();

    dmem_mmio #(.RAM_WORDS(1024), .ROM_WORDS(3), .GPIO_CH(2), .READ_LAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a), .switch(sw), .led(led_a));
    dmem_mmio #(.RAM_WORDS(64), .ROM_WORDS(3), .GPIO_CH(2), .READ_LAT(2)) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b), .switch(sw), .led(led_b));

    // Drive one request, wait (bounded) for its response; lat=0 means none came.
    task automatic do_req(input bit sel_b, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int waited = 0;
        @(negedge clk);
        if (sel_b) begin
            bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_funct3 = f3;
            bus_b.req_addr = addr; bus_b.req_wdata = wdata;
        end else begin
            bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_funct3 = f3;
            bus_a.req_addr = addr; bus_a.req_wdata = wdata;
        end
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        lat = 0; rdata = 'x; err = 1'bx;
        while (lat == 0 && waited < 6) begin
            @(negedge clk);
            waited++;
            if (sel_b ? bus_b.resp_valid : bus_a.resp_valid) begin
                lat   = waited;
                rdata = sel_b ? bus_b.resp_rdata : bus_a.resp_rdata;
                err   = sel_b ? bus_b.resp_err : bus_a.resp_err;
            end
        end
        $display("req %s we=%0b f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%b lat=%0d",
                 sel_b ? "B" : "A", we, f3, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus_a.req_ready !== 1'b0) $display("FAIL rst_ready_a: got %b want 0", bus_a.req_ready); else n_pass++;
        n_checks++; if (bus_b.req_ready !== 1'b0) $display("FAIL rst_ready_b: got %b want 0", bus_b.req_ready); else n_pass++;
        n_checks++; if (bus_a.resp_valid !== 1'b0 || bus_a.resp_err !== 1'b0) $display("FAIL rst_resp: got valid=%b err=%b want 0/0", bus_a.resp_valid, bus_a.resp_err); else n_pass++;
        n_checks++; if (bus_a.resp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus_a.resp_rdata); else n_pass++;
        n_checks++; if (led_a !== 32'h0) $display("FAIL rst_led: got %h want 0", led_a); else n_pass++;
        rstn = 1'b1;
        #1;
        n_checks++; if (bus_a.req_ready !== 1'b0) $display("FAIL ready_first_cycle: got %b want 0", bus_a.req_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus_a.req_ready !== 1'b1) $display("FAIL ready_after: got %b want 1", bus_a.req_ready); else n_pass++;
    endtask

    task automatic test_rom_counter();
        logic [31:0] rd, c1; logic er; int lt;
        do_req(0, 0, LW, 32'h0010_0000, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h444D454D || er !== 1'b0 || lt != 1) $display("FAIL rom0: got %h/%b/%0d want 444d454d/0/1", rd, er, lt); else n_pass++;
        do_req(0, 0, LW, 32'h0010_0008, 0, rd, er, lt);
        n_checks++; if (rd !== 32'hC0DEF00D || er !== 1'b0) $display("FAIL rom2: got %h/%b want c0def00d/0", rd, er); else n_pass++;
        do_req(0, 0, LW, 32'h0010_000C, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL rom_past_end: got %h/%b want 0/0", rd, er); else n_pass++;
        do_req(0, 0, LW, 32'h0010_0020, 0, c1, er, lt);
        do_req(0, 0, LW, 32'h0010_0020, 0, rd, er, lt);
        n_checks++; if (rd - c1 !== 32'd2) $display("FAIL counter_step: got delta %0d want 2", rd - c1); else n_pass++;
    endtask

    task automatic test_ram_bytes();
        logic [31:0] rd; logic er; int lt;
        do_req(0, 1, LW, 32'h8000_0010, 32'hDEADBEEF, rd, er, lt);
        n_checks++; if (rd !== 32'h0 || er !== 1'b0 || lt != 1) $display("FAIL sw_resp: got %h/%b/%0d want 0/0/1", rd, er, lt); else n_pass++;
        do_req(0, 0, LB, 32'h8000_0013, 0, rd, er, lt);
        n_checks++; if (rd !== 32'hFFFFFFDE || er !== 1'b0) $display("FAIL lb_sign: got %h/%b want ffffffde/0", rd, er); else n_pass++;
        do_req(0, 0, LBU, 32'h8000_0013, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h000000DE) $display("FAIL lbu: got %h want 000000de", rd); else n_pass++;
        do_req(0, 0, LH, 32'h8000_0010, 0, rd, er, lt);
        n_checks++; if (rd !== 32'hFFFFBEEF) $display("FAIL lh_sign: got %h want ffffbeef", rd); else n_pass++;
        do_req(0, 0, LHU, 32'h8000_0012, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0000DEAD) $display("FAIL lhu_upper: got %h want 0000dead", rd); else n_pass++;
        do_req(0, 1, LW, 32'h8000_0020, 32'h0, rd, er, lt);
        do_req(0, 1, LB, 32'h8000_0021, 32'h0000_00AA, rd, er, lt);
        do_req(0, 0, LW, 32'h8000_0020, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0000AA00) $display("FAIL sb_lane1: got %h want 0000aa00", rd); else n_pass++;
        do_req(0, 1, LH, 32'h8000_0022, 32'h7777_8001, rd, er, lt);
        do_req(0, 0, LW, 32'h8000_0020, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h8001AA00) $display("FAIL sh_upper: got %h want 8001aa00", rd); else n_pass++;
    endtask

    task automatic test_led();
        logic [31:0] rd; logic er; int lt;
        do_req(0, 1, LW, 32'h0010_0044, 32'h12345678, rd, er, lt);
        n_checks++; if (led_a !== 32'h0000_5678) $display("FAIL led_sw: got %h want 00005678", led_a); else n_pass++;
        do_req(0, 0, LW, 32'h0010_0044, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h00005678 || er !== 1'b0) $display("FAIL led_read: got %h/%b want 00005678/0", rd, er); else n_pass++;
        do_req(0, 1, LB, 32'h0010_0045, 32'h0000_00CC, rd, er, lt);
        n_checks++; if (led_a !== 32'h0000_CC78) $display("FAIL led_sb: got %h want 0000cc78", led_a); else n_pass++;
        do_req(0, 1, LH, 32'h0010_004E, 32'h0000_BEEF, rd, er, lt);
        n_checks++; if (led_a !== 32'h0000_CC78 || er !== 1'b0) $display("FAIL led_upper_drop: got %h/%b want 0000cc78/0", led_a, er); else n_pass++;
        do_req(0, 1, LW, 32'h0010_004C, 32'hABCD1234, rd, er, lt);
        n_checks++; if (led_a !== 32'h1234_CC78) $display("FAIL led_ch1: got %h want 1234cc78", led_a); else n_pass++;
    endtask

    task automatic test_switch();
        logic [31:0] rd; logic er; int lt;
        sw = 32'h00F0_1111;
        repeat (3) @(negedge clk);
        do_req(0, 0, LHU, 32'h0010_0048, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h000000F0 || er !== 1'b0) $display("FAIL sw_ch1: got %h/%b want 000000f0/0", rd, er); else n_pass++;
        do_req(0, 0, LB, 32'h0010_0048, 0, rd, er, lt);
        n_checks++; if (rd !== 32'hFFFFFFF0) $display("FAIL sw_lb: got %h want fffffff0", rd); else n_pass++;
        // New value applied now is still in flight when the next request is accepted.
        sw = 32'h00F0_2222;
        do_req(0, 0, LW, 32'h0010_0040, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h00001111) $display("FAIL sw_sync_depth: got %h want 00001111", rd); else n_pass++;
        do_req(0, 0, LW, 32'h0010_0040, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h00002222) $display("FAIL sw_sync_new: got %h want 00002222", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lt;
        do_req(0, 1, LW, 32'h8000_0000, 32'h11223344, rd, er, lt);
        do_req(0, 0, LW, 32'h8000_0002, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0 || er !== 1'b1 || lt != 1) $display("FAIL lw_misalign: got %h/%b/%0d want 0/1/1", rd, er, lt); else n_pass++;
        do_req(0, 1, LW, 32'h8000_0001, 32'h99999999, rd, er, lt);
        n_checks++; if (er !== 1'b1) $display("FAIL sw_misalign_err: got %b want 1", er); else n_pass++;
        do_req(0, 1, LH, 32'h8000_0003, 32'h99999999, rd, er, lt);
        do_req(0, 0, LW, 32'h8000_0000, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h11223344 || er !== 1'b0) $display("FAIL misalign_nowrite: got %h/%b want 11223344/0", rd, er); else n_pass++;
        do_req(0, 0, LHU, 32'h8000_0001, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL lhu_misalign: got %h/%b want 0/1", rd, er); else n_pass++;
        do_req(0, 0, LW, 32'h0000_0010, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL unmapped: got %h/%b want 0/1", rd, er); else n_pass++;
        do_req(0, 0, BAD_F3, 32'h8000_0000, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL bad_funct3: got %h/%b want 0/1", rd, er); else n_pass++;
        do_req(0, 1, LW, 32'h0010_0000, 32'h55555555, rd, er, lt);
        n_checks++; if (er !== 1'b0) $display("FAIL rom_write_err: got %b want 0", er); else n_pass++;
        do_req(0, 0, LW, 32'h0010_0000, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h444D454D) $display("FAIL rom_unchanged: got %h want 444d454d", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lt;
        logic        we_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] wd_tab [4] = '{32'hCAFEF00D, 32'h0, 32'h0BADBEEF, 32'h0};
        logic [31:0] exp_tab[4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0BADBEEF};
        do_req(1, 1, LW, 32'h0010_0044, 32'h0000_00A5, rd, er, lt);
        n_checks++; if (lt != 2 || er !== 1'b0 || led_b !== 32'h0000_00A5) $display("FAIL b_led_lat2: got lat=%0d err=%b led=%h want 2/0/000000a5", lt, er, led_b); else n_pass++;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t >= 2 && t <= 5) begin
                $display("b2b t=%0d valid=%b rdata=%08h err=%b", t, bus_b.resp_valid, bus_b.resp_rdata, bus_b.resp_err);
                n_checks++;
                if (bus_b.resp_valid !== 1'b1 || bus_b.resp_rdata !== exp_tab[t-2] || bus_b.resp_err !== 1'b0)
                    $display("FAIL b2b_resp%0d: got %b/%h/%b want 1/%h/0", t - 2, bus_b.resp_valid, bus_b.resp_rdata, bus_b.resp_err, exp_tab[t-2]);
                else n_pass++;
            end else begin
                n_checks++;
                if (bus_b.resp_valid !== 1'b0) $display("FAIL b2b_idle%0d: got valid=%b want 0", t, bus_b.resp_valid); else n_pass++;
            end
            if (t < 4) begin
                bus_b.req_valid = 1'b1; bus_b.req_we = we_tab[t]; bus_b.req_funct3 = LW;
                bus_b.req_addr = 32'h8000_0030; bus_b.req_wdata = wd_tab[t];
            end else begin
                bus_b.req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd; logic er; int lt;
        int stray = 0;
        @(negedge clk);
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_funct3 = LW; bus_b.req_addr = 32'h8000_0030;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        rstn = 1'b0;
        #1;
        n_checks++; if (led_b !== 32'h0 || led_a !== 32'h0) $display("FAIL rst_mid_led: got a=%h b=%h want 0/0", led_a, led_b); else n_pass++;
        n_checks++; if (bus_b.req_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", bus_b.req_ready); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (bus_b.resp_valid !== 1'b0) stray++;
        end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus_b.resp_valid !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) $display("FAIL rst_mid_stray: got %0d stray responses want 0", stray); else n_pass++;
        do_req(1, 0, LW, 32'h8000_0030, 0, rd, er, lt);
        n_checks++; if (rd !== 32'h0BADBEEF || er !== 1'b0 || lt != 2) $display("FAIL ram_kept: got %h/%b/%0d want 0badbeef/0/2", rd, er, lt); else n_pass++;
    endtask

    initial begin
        rstn = 1'b0;
        sw = 32'h0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_funct3 = 3'b0; bus_a.req_addr = 32'h0; bus_a.req_wdata = 32'h0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_funct3 = 3'b0; bus_b.req_addr = 32'h0; bus_b.req_wdata = 32'h0;
        test_reset();
        test_rom_counter();
        test_ram_bytes();
        test_led();
        test_switch();
        test_errors();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, RAM depth in 32-bit words, power of two, 16..4096.
REQ-002 SHALL have parameter ROM_WORDS, default 3, read-only ID words, 1..8.
REQ-003 SHALL have parameter GPIO_CH, default 2, number of 16-bit switch/LED channel pairs, 1..4.
REQ-004 SHALL have parameter READ_LAT, default 1, request-to-response latency in cycles, legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid input 1 and req_ready output 1, the request handshake.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have ports req_addr input 32 and req_wdata input 32; wdata is the unshifted register value.
REQ-011 SHALL have ports resp_valid output 1, resp_rdata output 32 (extended load data) and resp_err output 1.
REQ-012 SHALL have ports switch input 16*GPIO_CH and led output 16*GPIO_CH, channel n at bits [16n+15:16n].

Function
REQ-013 SHALL accept a request on any rising edge with req_valid=1 and req_ready=1.
REQ-014 SHALL drive req_ready=0 while rstn=0 and for the first cycle after release, then 1 permanently.
REQ-015 SHALL decode the address: addr[31]=1 selects RAM, using word index addr[log2(RAM_WORDS)+1:2]; addr[31]=0 with addr[20]=1 selects IO; anything else is unmapped.
REQ-016 SHALL map IO word indices (addr[11:2]): 0..ROM_WORDS-1 ROM; 8 cycle counter (RO); 16+2n switch ch n (RO); 17+2n LED ch n (RW); other indices read 0 and ignore writes.
REQ-017 SHALL flag misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0; such accesses write nothing and respond resp_err=1, rdata=0.
REQ-018 SHALL respond to unmapped or reserved-funct3 accesses with resp_err=1, rdata=0, no state change.
REQ-019 SHALL, on a store, derive byte enables from size and addr[1:0] and place wdata[7:0]/[15:0] onto the addressed lane(s).
REQ-020 SHALL, on a load, extract the addressed lane and sign-extend (B, H) or zero-extend (BU, HU).
REQ-021 SHALL assert resp_valid for exactly one cycle, READ_LAT cycles after acceptance, for every accepted request, including stores (rdata=0).
REQ-022 SHALL sustain one request per cycle, responses in order.
REQ-023 SHALL return old data for a load accepted in the same cycle as a store to the same word, and new data for a load in any later cycle.
REQ-024 SHALL treat writes to ROM, switch or counter words as ignored, err=0.
REQ-025 SHALL apply LED writes only to the enabled bytes of the addressed 16-bit channel; upper lanes of a W store are dropped.
REQ-026 SHALL pass each switch bit through a 2-flop synchroniser before it is readable.
REQ-027 SHALL increment the 32-bit cycle counter every cycle, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-028 SHALL, on rstn=0, immediately clear led, counter, synchroniser flops, pipeline valid bits, resp_valid, resp_err and resp_rdata to 0.
REQ-029 SHALL leave RAM contents unchanged by reset; any in-flight request is dropped with no response.

Structure
REQ-030 SHALL take from shared package dmem_pkg: region bit positions, IO index constants, funct3 encodings and ROM content words.
REQ-031 SHALL use one sub-module, load_ext (combinational lane extract plus extend), instantiated once at the output stage.

Verification
REQ-032 SHALL cover: SW 0xDEADBEEF to 0x80000010, then LB/LBU at 0x80000013 -> rdata 0xFFFFFFDE / 0x000000DE; LH at 0x80000010 -> 0xFFFFBEEF.
REQ-033 SHALL cover: SB 0x000000AA to 0x80000021 over a word holding 0 -> LW reads 0x0000AA00.
REQ-034 SHALL cover: SW 0x12345678 to 0x00100044 (LED ch0) -> led[15:0]=0x5678 next cycle; LW 0x00100044 -> 0x00005678.
REQ-035 SHALL cover: switch ch1=0x00F0, wait 3 cycles, LHU 0x00100048 -> 0x000000F0; LW at 0x80000002 -> resp_err=1, no write.
REQ-036 SHALL cover: back-to-back SW/LW same word with READ_LAT=2 -> load returns new data, resp_valid every cycle; rstn pulse mid-stream -> led=0, no stray resp_valid.
